// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry hold buffer for IF/ID stalls, redirect and halt handling.
// Optional FETCH_STATS_EN adds a saturating fetch_count output.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] out_iload,
  output logic [31:0] out_cpc,
  output logic        out_en,
  output logic        out_nop
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4, tgt;
  logic [31:0] hb_iload, hb_iload_nxt, hb_cpc, hb_cpc_nxt;

  assign pc4      = pc + 32'd4;
  assign tgt      = {redirect_pc[31:2], 2'b00};
  assign imemaddr = pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= {PC_INIT[31:2], 2'b00};
      hb_iload <= '0;
      hb_cpc   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      hb_iload <= hb_iload_nxt;
      hb_cpc   <= hb_cpc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    hb_iload_nxt = hb_iload;
    hb_cpc_nxt   = hb_cpc;
    imemREN      = 1'b0;
    out_en       = 1'b0;
    out_nop      = 1'b0;
    out_iload    = '0;
    out_cpc      = '0;
    case (state)
      FETCH: begin
        imemREN   = 1'b1;
        out_iload = imemload;
        out_cpc   = pc4;
        if (halt) begin
          state_nxt = HALTED;
        end else if (redirect) begin
          pc_nxt       = tgt;
          out_nop      = 1'b1;
          hb_iload_nxt = '0;
          hb_cpc_nxt   = '0;
        end else if (ihit) begin
          pc_nxt = pc4;
          if (stall) begin
            // IF/ID is full: park the word so the fetch is not lost
            hb_iload_nxt = imemload;
            hb_cpc_nxt   = pc4;
            state_nxt    = HOLD;
          end else begin
            out_en = 1'b1;
          end
        end
      end
      HOLD: begin
        out_iload = hb_iload;
        out_cpc   = hb_cpc;
        if (halt) begin
          state_nxt = HALTED;
        end else if (redirect) begin
          pc_nxt       = tgt;
          out_nop      = 1'b1;
          hb_iload_nxt = '0;
          hb_cpc_nxt   = '0;
          state_nxt    = FETCH;
        end else if (!stall) begin
          out_en    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: ;
    endcase
    // Outputs are quiet while reset is asserted, whatever the state
    if (RST) begin
      imemREN   = 1'b0;
      out_en    = 1'b0;
      out_nop   = 1'b0;
      out_iload = '0;
      out_cpc   = '0;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST)
      fetch_count <= '0;
    else if (out_en && fetch_count != 32'hFFFF_FFFF)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1 bit: the IF/ID register cannot accept a new instruction this cycle.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken branch or jump from a later stage.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-007 The block SHALL have port halt, input, 1 bit: a halt has been decoded and fetch must stop.
REQ-008 The block SHALL have port imemREN, output, 1 bit: instruction memory read request.
REQ-009 The block SHALL have port imemaddr, output, 32 bits: the instruction memory address, equal to the current PC.
REQ-010 The block SHALL have port ihit, input, 1 bit: imemload is valid this cycle.
REQ-011 The block SHALL have port imemload, input, 32 bits: the fetched instruction word.
REQ-012 The block SHALL have port out_iload, output, 32 bits: the instruction word driven to IF/ID in_iload.
REQ-013 The block SHALL have port out_cpc, output, 32 bits: the fetched PC+4, driven to IF/ID in_cpc.
REQ-014 The block SHALL have port out_en, output, 1 bit: the IF/ID enable; out_iload and out_cpc are valid while it is high.
REQ-015 The block SHALL have port out_nop, output, 1 bit: the IF/ID flush.

Function
REQ-016 The block SHALL implement three states, FETCH, HOLD and HALTED, and SHALL enter FETCH on reset.
REQ-017 In FETCH, imemREN SHALL be 1 and imemaddr SHALL equal pc.
REQ-018 In FETCH with ihit=1, stall=0, redirect=0 and halt=0, the block SHALL combinationally drive out_en=1, out_iload=imemload and out_cpc=pc+4, SHALL set pc to pc+4 at the next edge, and SHALL remain in FETCH.
REQ-019 In FETCH with ihit=1, stall=1 and redirect=0, the block SHALL capture imemload and pc+4 into a one-entry hold buffer, SHALL set pc to pc+4, SHALL enter HOLD, and SHALL drive out_en=0.
REQ-020 In HOLD, imemREN SHALL be 0 and the block SHALL drive out_iload and out_cpc from the hold buffer.
REQ-021 In HOLD, out_en SHALL be asserted only when stall=0; that same cycle the block SHALL return to FETCH, so the held word is delivered exactly once.
REQ-022 In FETCH with ihit=0, out_en SHALL be 0 and pc SHALL be unchanged.
REQ-023 A redirect=1 in FETCH or HOLD SHALL take priority over ihit and stall: pc SHALL be set to {redirect_pc[31:2],2'b00}.
REQ-024 On such a redirect, any same-cycle fetched word and any held word SHALL be discarded.
REQ-025 On such a redirect, out_nop SHALL be 1 and out_en SHALL be 0 for that cycle, and the next state SHALL be FETCH.
REQ-026 halt=1 SHALL take priority over redirect: the block SHALL enter HALTED, and imemREN, out_en and out_nop SHALL be 0 in HALTED.
REQ-027 The block SHALL leave HALTED only on reset.
REQ-028 PC arithmetic SHALL be 32-bit modulo, so 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-029 pc[1:0] SHALL always be 2'b00.
REQ-030 out_nop SHALL be 0 in every cycle that has no redirect.

Reset
REQ-031 With RST=1 at a rising edge, the block SHALL set pc=PC_INIT, state=FETCH and hold buffer=0, overriding every other input, including one in the middle of a HOLD or a redirect.
REQ-032 During reset, outputs SHALL be imemREN=0, out_en=0, out_nop=0, out_iload=0 and out_cpc=0.

Configuration
REQ-033 With macro FETCH_STATS_EN defined, the block SHALL add a 32-bit output fetch_count that counts cycles with out_en=1, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-034 Without FETCH_STATS_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-035 Reset with PC_INIT=0, then ihit=1 every cycle with stall=0 -> imemaddr steps 0,4,8; out_cpc=4,8,12; out_en=1 each cycle.
REQ-036 At pc=8, ihit=1 with imemload=32'h2001_0005 and stall=1 for 3 cycles -> HOLD, imemREN=0; at stall release out_en=1 once, out_iload=32'h2001_0005, out_cpc=12; next imemaddr=12.
REQ-037 In HOLD, redirect=1 with redirect_pc=32'h0000_0103 -> out_nop=1 that cycle, held word dropped, next imemaddr=32'h0000_0100.
REQ-038 In FETCH, ihit=1 with redirect=1 and halt=1 in the same cycle -> HALTED, imemREN=0 thereafter; RST=1 returns imemaddr to PC_INIT.
REQ-039 pc=32'hFFFF_FFFC with ihit=1 -> out_cpc=0 and next imemaddr=0.
REQ-040 With FETCH_STATS_EN defined, 5 accepted fetches plus 2 stalled cycles -> fetch_count=5; with RST=1 mid-stream -> fetch_count=0.
